mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/wam_pkg.sv | 35 +++
 rtl/lfsr8.sv | 24 ++
 rtl/mole_scheduler.sv | 132 +++++++++++++
 tb/tb_mole_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole scheduler: FSM encoding,
// the "no mole" column code, LFSR taps and column helpers.
package wam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] NO_COL    = 2'd3;
    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [1:0] pick_col(input logic [7:0] v);
        logic [1:0] c;
        c = v[1:0];
        if (c == NO_COL) c = v[3:2];
        if (c == NO_COL) c = 2'd1;
        return c;
    endfunction

    function automatic logic [2:0] col_decode(input logic [1:0] c);
        logic [2:0] d;
        case (c)
            2'd0:    d = 3'b001;
            2'd1:    d = 3'b010;
            2'd2:    d = 3'b100;
            default: d = 3'b000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; advances every clock after reset.
module lfsr8
    import wam_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: alternates idle gaps with timed mole windows,
// scores edge-detected hits on the shown column and counts timeouts.
module mole_scheduler
    import wam_pkg::*;
#(
    parameter int unsigned UP_CYCLES  = 50,
    parameter int unsigned GAP_CYCLES = 25,
    parameter int unsigned ROUNDS     = 10,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] hit,
    output logic [1:0] col_sel,
    output logic       mole_active,
    output logic [7:0] score,
    output logic [7:0] miss_cnt,
    output logic       done
);

    localparam logic [15:0] UP_LAST   = 16'(UP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  ROUNDS_8  = 8'(ROUNDS);

    state_t      r_state;
    logic [15:0] r_cyc;
    logic [7:0]  r_round;
    logic [2:0]  r_hit_q;
    logic [1:0]  r_col_sel;
    logic        r_mole_active;
    logic [7:0]  r_score;
    logic [7:0]  r_miss_cnt;
    logic        r_done;

    logic [7:0]  w_lfsr;
    logic [2:0]  w_hit_rise;
    logic        w_hit_ok;
    logic        w_up_last;
    logic        w_round_end;
    logic [7:0]  w_round_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .q      (w_lfsr)
    );

    // Only a fresh press on the column currently shown counts; col_sel is
    // NO_COL outside UP, so the decode also masks hits in other states.
    assign w_hit_rise  = hit & ~r_hit_q;
    assign w_hit_ok    = (r_state == ST_UP) && (|(w_hit_rise & col_decode(r_col_sel)));
    assign w_up_last   = (r_state == ST_UP) && (r_cyc == UP_LAST);
    assign w_round_end = w_hit_ok || w_up_last;
    assign w_round_nxt = r_round + 8'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_cyc         <= '0;
            r_round       <= '0;
            r_hit_q       <= '0;
            r_col_sel     <= NO_COL;
            r_mole_active <= 1'b0;
            r_score       <= '0;
            r_miss_cnt    <= '0;
            r_done        <= 1'b0;
        end else begin
            r_hit_q <= hit;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_GAP;
                        r_cyc         <= '0;
                        r_round       <= '0;
                        r_score       <= '0;
                        r_miss_cnt    <= '0;
                        r_done        <= 1'b0;
                        r_col_sel     <= NO_COL;
                        r_mole_active <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (r_cyc == GAP_LAST) begin
                        r_state       <= ST_UP;
                        r_cyc         <= '0;
                        r_col_sel     <= pick_col(w_lfsr);
                        r_mole_active <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 16'd1;
                    end
                end
                ST_UP: begin
                    // A hit on the final cycle wins over the timeout
                    if (w_hit_ok) begin
                        r_score <= sat_inc(r_score);
                    end else if (w_up_last) begin
                        r_miss_cnt <= sat_inc(r_miss_cnt);
                    end
                    if (w_round_end) begin
                        r_cyc         <= '0;
                        r_round       <= w_round_nxt;
                        r_col_sel     <= NO_COL;
                        r_mole_active <= 1'b0;
                        if (w_round_nxt == ROUNDS_8) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_cyc <= r_cyc + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign col_sel     = r_col_sel;
    assign mole_active = r_mole_active;
    assign score       = r_score;
    assign miss_cnt    = r_miss_cnt;
    assign done        = r_done;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with UP=4, GAP=2, ROUNDS=3.
module tb_mole_scheduler;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [2:0] hit;
    logic [1:0] col_sel;
    logic       mole_active;
    logic [7:0] score;
    logic [7:0] miss_cnt;
    logic       done;

    mole_scheduler #(
        .UP_CYCLES  (4),
        .GAP_CYCLES (2),
        .ROUNDS     (3),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .hit         (hit),
        .col_sel     (col_sel),
        .mole_active (mole_active),
        .score       (score),
        .miss_cnt    (miss_cnt),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hm: 0 no press, 1 shown column, 2 a different column, 3 all buttons
    typedef struct {
        logic       st;
        logic [1:0] hm;
        logic       ma;
        int         sc;
        int         ms;
        logic       dn;
    } vec_t;

    vec_t       vq[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    logic [1:0] m_col;
    logic [1:0] g1col;
    logic       g1_set;

    function automatic logic [7:0] model_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    function automatic logic [1:0] model_pick(input logic [7:0] v);
        if (v[1:0] != 2'd3) return v[1:0];
        if (v[3:2] != 2'd3) return v[3:2];
        return 2'd1;
    endfunction

    function automatic logic [2:0] hit_vec(input logic [1:0] hm, input logic [1:0] c);
        case (hm)
            2'd1:    return 3'b001 << c;
            2'd2:    return 3'b001 << ((c + 2'd1) % 3);
            2'd3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic add(input logic s, input logic [1:0] h, input logic ma,
                       input int sc, input int ms, input logic dn);
        vec_t v;
        v.st = s; v.hm = h; v.ma = ma; v.sc = sc; v.ms = ms; v.dn = dn;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        m_prev = m_lfsr;
        m_lfsr = model_next(m_lfsr);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ecol, input logic ema,
                           input int esc, input int ems, input logic edn);
        chk({tag, " col_sel"}, col_sel, ecol);
        chk({tag, " mole_active"}, mole_active, ema);
        chk({tag, " score"}, score, esc);
        chk({tag, " miss_cnt"}, miss_cnt, ems);
        chk({tag, " done"}, done, edn);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_ma;
        logic dut_prev_ma;
        int   rounds;
        int   budget;
        int   ecol;
        bit   seen [3];

        resetn = 1'b0;
        start  = 1'b0;
        hit    = 3'b000;
        m_lfsr = 8'hA5;
        m_prev = 8'hA5;
        m_col  = 2'd0;
        g1col  = 2'd0;
        g1_set = 1'b0;

        // Idle after reset, then a no-hit game that times out every mole
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) add(0, 0, 1, 0, r, 0);
            if (r < 2) begin
                add(0, 0, 0, 0, r + 1, 0);
                add(0, 0, 0, 0, r + 1, 0);
            end
        end
        add(0, 0, 0, 0, 3, 1);
        add(0, 3, 0, 0, 3, 1);
        // Restart from DONE: GAP press ignored, wrong then right column,
        // final-cycle hit, then a held press that must not score again
        add(1, 0, 0, 0, 0, 0);
        add(0, 3, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 2, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(0, 3, 0, 2, 0, 0);
        add(0, 3, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 3, 1, 2, 0, 0);
        add(0, 3, 0, 2, 1, 1);
        add(0, 0, 0, 2, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 3, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        prev_ma = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].st;
            hit   = hit_vec(vq[i].hm, m_col);
            step();
            if (vq[i].ma && !prev_ma) begin
                m_col = model_pick(m_prev);
                if (!g1_set) begin
                    g1col  = m_col;
                    g1_set = 1'b1;
                end
            end
            prev_ma = vq[i].ma;
            ecol = vq[i].ma ? int'(m_col) : 3;
            chk_all($sformatf("vec%0d", i), ecol, vq[i].ma, vq[i].sc, vq[i].ms, vq[i].dn);
        end
        start = 1'b0;
        hit   = 3'b000;

        // Score a point, then pull reset in the middle of the next mole
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        m_col = model_pick(m_prev);
        chk_all("rst_seq up1", int'(m_col), 1, 0, 0, 0);
        hit = 3'b001 << m_col;
        step();
        chk_all("rst_seq hit", 3, 0, 1, 0, 0);
        hit = 3'b000;
        step();
        step();
        m_col = model_pick(m_prev);
        chk_all("rst_seq up2", int'(m_col), 1, 1, 0, 0);
        #2;
        resetn = 1'b0;
        m_lfsr = 8'hA5;
        #1;
        chk_all("rst_async", 3, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        m_col = model_pick(m_prev);
        chk("replay first col", col_sel, g1col);
        chk_all("replay up", int'(m_col), 1, 0, 0, 0);

        // Long run of unattended games checking each chosen column
        rounds      = 0;
        budget      = 20000;
        dut_prev_ma = mole_active;
        seen[0] = 0; seen[1] = 0; seen[2] = 0;
        while (rounds < 1000 && budget > 0) begin
            start = done;
            step();
            budget--;
            if (mole_active && !dut_prev_ma) begin
                chk($sformatf("long col r%0d", rounds), col_sel, model_pick(m_prev));
                if (col_sel != 2'd3) seen[col_sel] = 1;
                rounds++;
            end
            dut_prev_ma = mole_active;
        end
        start = 1'b0;
        chk("long rounds reached", rounds, 1000);
        chk("col0 seen", seen[0], 1);
        chk("col1 seen", seen[1], 1);
        chk("col2 seen", seen[2], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
